regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
//
// PURPOSE
//   Writeback stage that sits directly upstream of registerfile.
//   Merges results from the ALU and the load unit into one registered
//   write per cycle: one-hot reg_write_en, write_data and write_en.
//   Load responses are buffered in a small FIFO; the ALU has priority.
//   A starvation counter guarantees forward progress for loads.
//
// PARAMETERS
//   WIDTH      32  data width; must equal registerfile WIDTH
//   LENGTH     32  register count; must equal registerfile LENGTH
//   ADDR_W     5   register index width; LENGTH <= 2**ADDR_W
//   DEPTH      4   load FIFO entries; power of two, >= 2
//   STARVE_MAX 3   ALU wins while FIFO non-empty before the FIFO is forced
//
// PORTS
//   clk           in   1       clock, rising edge
//   rst           in   1       asynchronous reset, active-high
//   alu_valid     in   1       ALU result present
//   alu_ready     out  1       ALU result accepted this cycle when high
//   alu_rd        in   ADDR_W  ALU destination register
//   alu_data      in   WIDTH   ALU result
//   mem_valid     in   1       load response present
//   mem_ready     out  1       FIFO has space (= !full)
//   mem_rd        in   ADDR_W  load destination register
//   mem_data      in   WIDTH   load data
//   reg_write_en  out  LENGTH  one-hot write enable to registerfile
//   write_data    out  WIDTH   data to registerfile
//   write_en      out  1       high when any reg_write_en bit is set
//   fifo_count    out  log2(DEPTH)+1  occupancy, for debug/perf
//
// BEHAVIOUR
//   - Reset (async, immediate): reg_write_en=0, write_en=0, write_data=0,
//     FIFO empty (fifo_count=0), starve_cnt=0. After reset alu_ready=1
//     and mem_ready=1. Reset mid-operation discards FIFO contents and any
//     pending write.
//   - Handshake: a transfer occurs on a rising edge with valid&&ready.
//     Sources hold rd/data stable until accepted. ready does not depend
//     on valid.
//   - force_mem = (fifo_count!=0) && (starve_cnt==STARVE_MAX).
//     alu_ready = !force_mem.
//   - Per-cycle select, in priority order:
//     (1) force_mem -> FIFO head.
//     (2) alu_valid -> ALU.
//     (3) FIFO non-empty -> FIFO head.
//     (4) none.
//   - Latency: the ALU is written 1 cycle after acceptance (registered
//     outputs). A load has a minimum of 2 cycles: push, then pop, then
//     output. There is no FIFO bypass.
//   - Output register, next cycle after select:
//     - selected && rd!=0: write_en=1, reg_write_en[rd]=1 (only that bit),
//       write_data=data.
//     - selected && rd==0: consumed, no write; all outputs 0.
//     - rd >= LENGTH: consumed, no write.
//     - none: reg_write_en=0, write_en=0, write_data=0.
//   - FIFO push: mem_valid && mem_ready. Pop: FIFO head selected.
//     - Push and pop in the same cycle are allowed when not full;
//       count is unchanged.
//     - Pointers wrap modulo DEPTH.
//     - When full, mem_ready=0 even if a pop occurs that cycle.
//   - starve_cnt:
//     - Reset to 0 on a FIFO pop or when the FIFO is empty.
//     - Increments when the ALU is selected while the FIFO is non-empty.
//     - Saturates at STARVE_MAX.
//   - Order: loads write in arrival order. An ALU write and a FIFO write
//     to the same rd are not reordered relative to select order.
//
// TESTING
//   1. ALU alu_rd=5, alu_data=0xDEADBEEF, FIFO empty -> next cycle
//      write_en=1, only reg_write_en[5]=1, write_data=0xDEADBEEF.
//   2. ALU alu_rd=0, alu_data=0x1 -> accepted (alu_ready=1); next cycle
//      write_en=0, reg_write_en=0.
//   3. ALU idle, mem_rd=7, mem_data=0x1234 pushed at cycle t -> write_en=1,
//      reg_write_en[7]=1, write_data=0x1234 at t+2; fifo_count back to 0.
//   4. ALU valid every cycle, 5 loads offered -> after 4 pushes
//      mem_ready=0. After 3 ALU wins, alu_ready=0 for 1 cycle and the FIFO
//      head is written. Then mem_ready returns to 1.
//   5. FIFO holds 2 entries, rst pulsed asynchronously mid-cycle ->
//      outputs 0 immediately, fifo_count=0, alu_ready=mem_ready=1, and no
//      stale write after release.
//   6. Push and pop in the same cycle with fifo_count=2, plus 8
//      consecutive loads -> count stays 2 across the push/pop, pointers
//      wrap, and data exits in push order.

Source files
------------

// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Writeback stage feeding the register file. Each cycle it picks one result,
//   from either the ALU or a small load-response FIFO, and issues one
//   registered write. The ALU has priority. A starvation counter forces the
//   FIFO head through after STARVE_MAX consecutive ALU wins while loads wait.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   alu_valid/ready/rd/data  ALU result handshake
//   mem_valid/ready/rd/data  load response handshake (ready = FIFO not full)
//   reg_write_en             one-hot register write enable
//   write_data               write data
//   write_en                 high when any reg_write_en bit is set
//   fifo_count               load FIFO occupancy
module regfile_writeback #(
    parameter int WIDTH      = 32,
    parameter int LENGTH     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [WIDTH-1:0]         alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_rd,
    input  logic [WIDTH-1:0]         mem_data,
    output logic [LENGTH-1:0]        reg_write_en,
    output logic [WIDTH-1:0]         write_data,
    output logic                     write_en,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ST_W    = $clog2(STARVE_MAX + 1);
    localparam int ENTRY_W = ADDR_W + WIDTH;

    logic [ENTRY_W-1:0] fifo_mem_q [DEPTH];
    logic [ENTRY_W-1:0] fifo_mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ST_W-1:0]    starve_q, starve_d;
    logic [LENGTH-1:0]  reg_write_en_q, reg_write_en_d;
    logic [WIDTH-1:0]   write_data_q, write_data_d;
    logic               write_en_q, write_en_d;

    logic               fifo_empty, fifo_full, force_mem;
    logic               sel_alu, sel_fifo, push, pop;
    logic [ADDR_W-1:0]  head_rd, sel_rd;
    logic [WIDTH-1:0]   head_data, sel_data;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(DEPTH));
        force_mem  = !fifo_empty && (starve_q == ST_W'(STARVE_MAX));
        {head_rd, head_data} = fifo_mem_q[rd_ptr_q];

        // Priority: forced FIFO, then ALU, then FIFO when the ALU is idle.
        sel_fifo = force_mem || (!alu_valid && !fifo_empty);
        sel_alu  = !force_mem && alu_valid;
        sel_rd   = sel_fifo ? head_rd   : alu_rd;
        sel_data = sel_fifo ? head_data : alu_data;

        // Ready is gated by the current occupancy only, so a pop on a full
        // FIFO does not open a slot in the same cycle.
        push = mem_valid && !fifo_full;
        pop  = sel_fifo;

        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {mem_rd, mem_data};
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (sel_alu && (starve_q != ST_W'(STARVE_MAX))) begin
            starve_d = starve_q + ST_W'(1);
        end

        // rd==0 and out-of-range rd are consumed without a write.
        reg_write_en_d = '0;
        write_data_d   = '0;
        write_en_d     = 1'b0;
        if ((sel_alu || sel_fifo) && (sel_rd != '0) && (int'(sel_rd) < LENGTH)) begin
            reg_write_en_d = LENGTH'(1) << sel_rd;
            write_data_d   = sel_data;
            write_en_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            starve_q       <= '0;
            reg_write_en_q <= '0;
            write_data_q   <= '0;
            write_en_q     <= 1'b0;
        end else begin
            fifo_mem_q     <= fifo_mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            starve_q       <= starve_d;
            reg_write_en_q <= reg_write_en_d;
            write_data_q   <= write_data_d;
            write_en_q     <= write_en_d;
        end
    end

    assign alu_ready    = !force_mem;
    assign mem_ready    = !fifo_full;
    assign reg_write_en = reg_write_en_q;
    assign write_data   = write_data_q;
    assign write_en     = write_en_q;
    assign fifo_count   = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback
//   Directed bench for regfile_writeback with default parameters. Inputs are
//   driven on the falling edge; registered outputs are checked on the next
//   falling edge, ready/count checks apply to the cycle being set up.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic [31:0] reg_write_en;
    logic [31:0] write_data;
    logic        write_en;
    logic [2:0]  fifo_count;

    int tests = 0;
    int fails = 0;

    regfile_writeback #(
        .WIDTH(32), .LENGTH(32), .ADDR_W(5), .DEPTH(4), .STARVE_MAX(3)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .reg_write_en(reg_write_en), .write_data(write_data),
        .write_en(write_en), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [31:0] rwe,
                           input logic [31:0] wd);
        chk({tag, ".write_en"}, 64'(write_en), 64'(we));
        chk({tag, ".reg_write_en"}, 64'(reg_write_en), 64'(rwe));
        chk({tag, ".write_data"}, 64'(write_data), 64'(wd));
    endtask

    task automatic set_mem(input logic [4:0] rd, input logic [31:0] d);
        mem_valid = 1'b1;
        mem_rd    = rd;
        mem_data  = d;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    initial begin
        // Reset state
        #1;
        chk_out("reset", 1'b0, 32'h0, 32'h0);
        chk("reset.count", 64'(fifo_count), 64'd0);
        chk("reset.alu_ready", 64'(alu_ready), 64'd1);
        chk("reset.mem_ready", 64'(mem_ready), 64'd1);

        // 1: ALU write to r5
        @(negedge clk);
        rst = 1'b0;
        set_alu(5'd5, 32'hDEADBEEF);
        chk("t1.alu_ready", 64'(alu_ready), 64'd1);

        // 2: ALU write to r0 is consumed silently
        @(negedge clk);
        chk_out("t1", 1'b1, 32'h0000_0020, 32'hDEADBEEF);
        set_alu(5'd0, 32'h1);
        chk("t2.alu_ready", 64'(alu_ready), 64'd1);

        // 3: single load, two-cycle latency
        @(negedge clk);
        chk_out("t2", 1'b0, 32'h0, 32'h0);
        alu_valid = 1'b0;
        set_mem(5'd7, 32'h1234);
        chk("t3.mem_ready", 64'(mem_ready), 64'd1);
        @(negedge clk);
        mem_valid = 1'b0;
        chk("t3.count_mid", 64'(fifo_count), 64'd1);
        chk_out("t3.nobypass", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_out("t3", 1'b1, 32'h0000_0080, 32'h1234);
        chk("t3.count", 64'(fifo_count), 64'd0);

        // 4: ALU every cycle, 5 loads; starvation forces FIFO head after 3 wins
        set_alu(5'd1, 32'hA000_0000);
        set_mem(5'd10, 32'h100);
        chk("t4.c0.alu_ready", 64'(alu_ready), 64'd1);
        @(negedge clk);
        chk_out("t4.c1", 1'b1, 32'h2, 32'hA000_0000);
        chk("t4.c1.count", 64'(fifo_count), 64'd1);
        set_alu(5'd1, 32'hA000_0001);
        set_mem(5'd11, 32'h101);
        @(negedge clk);
        chk_out("t4.c2", 1'b1, 32'h2, 32'hA000_0001);
        chk("t4.c2.count", 64'(fifo_count), 64'd2);
        chk("t4.c2.alu_ready", 64'(alu_ready), 64'd1);
        set_alu(5'd1, 32'hA000_0002);
        set_mem(5'd12, 32'h102);
        @(negedge clk);
        chk_out("t4.c3", 1'b1, 32'h2, 32'hA000_0002);
        chk("t4.c3.count", 64'(fifo_count), 64'd3);
        chk("t4.c3.alu_ready", 64'(alu_ready), 64'd1);
        set_alu(5'd1, 32'hA000_0003);
        set_mem(5'd13, 32'h103);
        @(negedge clk);
        chk_out("t4.c4", 1'b1, 32'h2, 32'hA000_0003);
        chk("t4.c4.count", 64'(fifo_count), 64'd4);
        chk("t4.c4.mem_ready", 64'(mem_ready), 64'd0);
        chk("t4.c4.alu_ready", 64'(alu_ready), 64'd0);
        set_alu(5'd1, 32'hA000_0004);
        set_mem(5'd14, 32'h104);
        @(negedge clk);
        chk_out("t4.c5.forced", 1'b1, 32'h0000_0400, 32'h100);
        chk("t4.c5.count", 64'(fifo_count), 64'd3);
        chk("t4.c5.mem_ready", 64'(mem_ready), 64'd1);
        chk("t4.c5.alu_ready", 64'(alu_ready), 64'd1);
        @(negedge clk);
        chk_out("t4.c6", 1'b1, 32'h2, 32'hA000_0004);
        chk("t4.c6.count", 64'(fifo_count), 64'd4);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        chk_out("t4.d1", 1'b1, 32'h0000_0800, 32'h101);
        chk("t4.d1.count", 64'(fifo_count), 64'd3);
        @(negedge clk);
        chk_out("t4.d2", 1'b1, 32'h0000_1000, 32'h102);
        chk("t4.d2.count", 64'(fifo_count), 64'd2);
        @(negedge clk);
        chk_out("t4.d3", 1'b1, 32'h0000_2000, 32'h103);
        chk("t4.d3.count", 64'(fifo_count), 64'd1);
        @(negedge clk);
        chk_out("t4.d4", 1'b1, 32'h0000_4000, 32'h104);
        chk("t4.d4.count", 64'(fifo_count), 64'd0);
        @(negedge clk);
        chk_out("t4.idle", 1'b0, 32'h0, 32'h0);

        // 5: async reset with two loads buffered and an ALU write pending
        set_alu(5'd2, 32'h55);
        set_mem(5'd20, 32'h200);
        @(negedge clk);
        set_mem(5'd21, 32'h201);
        @(negedge clk);
        mem_valid = 1'b0;
        chk("t5.count_pre", 64'(fifo_count), 64'd2);
        chk_out("t5.pre", 1'b1, 32'h4, 32'h55);
        #2;
        rst = 1'b1;
        #1;
        chk_out("t5.rst", 1'b0, 32'h0, 32'h0);
        chk("t5.rst.count", 64'(fifo_count), 64'd0);
        chk("t5.rst.alu_ready", 64'(alu_ready), 64'd1);
        chk("t5.rst.mem_ready", 64'(mem_ready), 64'd1);
        alu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_out("t5.post", 1'b0, 32'h0, 32'h0);
            chk("t5.post.count", 64'(fifo_count), 64'd0);
        end

        // 6: two buffered loads, then push+pop each cycle across 8 loads
        set_alu(5'd3, 32'h33);
        set_mem(5'd8, 32'h300);
        @(negedge clk);
        chk_out("t6.alu0", 1'b1, 32'h8, 32'h33);
        chk("t6.count1", 64'(fifo_count), 64'd1);
        set_mem(5'd9, 32'h301);
        @(negedge clk);
        chk_out("t6.alu1", 1'b1, 32'h8, 32'h33);
        chk("t6.count2", 64'(fifo_count), 64'd2);
        alu_valid = 1'b0;
        set_mem(5'd10, 32'h302);
        for (int k = 3; k <= 8; k++) begin
            @(negedge clk);
            chk_out("t6.stream", 1'b1, 32'h1 << (8 + k - 3), 32'h300 + 32'(k - 3));
            chk("t6.stream.count", 64'(fifo_count), 64'd2);
            if (k <= 7) begin
                set_mem(5'(8 + k), 32'h300 + 32'(k));
            end else begin
                mem_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk_out("t6.tail6", 1'b1, 32'h1 << 14, 32'h306);
        chk("t6.tail6.count", 64'(fifo_count), 64'd1);
        @(negedge clk);
        chk_out("t6.tail7", 1'b1, 32'h1 << 15, 32'h307);
        chk("t6.tail7.count", 64'(fifo_count), 64'd0);
        @(negedge clk);
        chk_out("t6.idle", 1'b0, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
